// File: rtl/trace_dump_ctrl.sv
// trace_dump_ctrl: reads a completed circular capture oldest-first and
// streams it byte by byte to the UART, then re-arms the capture engine.
// Optional build macro DUMP_HDR_EN: prefixes each dump with two header
// bytes (0xA5, then {6'b0, chan_sel}).
module trace_dump_ctrl #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_req,
  input  logic [1:0]    dump_chan,
  input  logic          dump_abort,
  input  logic          capture_done,
  input  logic [AW-1:0] trace_end,
  input  logic [DW-1:0] ram_rdata,
  input  logic          tx_done,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [1:0]    chan_sel,
  output logic [DW-1:0] tx_data,
  output logic          trmt,
  output logic          clr_capture_done,
  output logic          dump_busy,
  output logic          dump_err
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    SEND,
    WTX,
    FIN
`ifdef DUMP_HDR_EN
    , HDR
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]    chan_sel_q, chan_sel_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dump_err_q, dump_err_d;
`ifdef DUMP_HDR_EN
  // 0 and 1 select the header byte being sent; 2 means header finished
  logic [1:0]    hdr_idx_q, hdr_idx_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      chan_sel_q <= '0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      dump_err_q <= 1'b0;
`ifdef DUMP_HDR_EN
      hdr_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      chan_sel_q <= chan_sel_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
      dump_err_q <= dump_err_d;
`ifdef DUMP_HDR_EN
      hdr_idx_q  <= hdr_idx_d;
`endif
    end
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_d          = state_q;
    ram_addr_d       = ram_addr_q;
    chan_sel_d       = chan_sel_q;
    tx_data_d        = tx_data_q;
    cnt_d            = cnt_q;
    dump_err_d       = 1'b0;
`ifdef DUMP_HDR_EN
    hdr_idx_d        = hdr_idx_q;
`endif
    ram_en           = 1'b0;
    trmt             = 1'b0;
    clr_capture_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (dump_req) begin
          if (capture_done) begin
            chan_sel_d = dump_chan;
            // oldest sample sits just past the last written one
            ram_addr_d = trace_end + AW'(1);
            cnt_d      = '0;
`ifdef DUMP_HDR_EN
            hdr_idx_d  = '0;
            state_d    = HDR;
`else
            state_d    = RD;
`endif
          end else begin
            dump_err_d = 1'b1;
          end
        end
      end
      RD: begin
        ram_en  = 1'b1;
        state_d = LAT;
      end
      LAT: begin
        tx_data_d = ram_rdata;
        state_d   = SEND;
      end
      SEND: begin
        trmt    = 1'b1;
        state_d = WTX;
      end
      WTX: begin
        if (tx_done) begin
`ifdef DUMP_HDR_EN
          if (!hdr_idx_q[1]) begin
            hdr_idx_d = hdr_idx_q + 2'd1;
            state_d   = hdr_idx_q[0] ? RD : HDR;
          end else
`endif
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = FIN;
          end else begin
            ram_addr_d = ram_addr_q + AW'(1);
            cnt_d      = cnt_q + AW'(1);
            state_d    = RD;
          end
        end
      end
      FIN: begin
        clr_capture_done = 1'b1;
        state_d          = IDLE;
      end
`ifdef DUMP_HDR_EN
      HDR: begin
        tx_data_d = hdr_idx_q[0] ? DW'({6'b0, chan_sel_q}) : DW'(8'hA5);
        state_d   = SEND;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a coincident tx_done; the
    // same-cycle strobes are suppressed so a dropped dump emits nothing more.
    if (dump_abort && (state_q != IDLE)) begin
      state_d          = IDLE;
      ram_en           = 1'b0;
      trmt             = 1'b0;
      clr_capture_done = 1'b0;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign chan_sel  = chan_sel_q;
  assign tx_data   = tx_data_q;
  assign dump_err  = dump_err_q;
  assign dump_busy = (state_q != IDLE);

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// Directed bench for trace_dump_ctrl with a RAM model (RAM[a] = a[7:0])
// and a UART model that answers each trmt with tx_done a few cycles later.
module tb_trace_dump_ctrl;

  localparam int DEPTH    = 512;
  localparam int AW       = 9;
  localparam int DW       = 8;
  localparam int UART_LAT = 3;
`ifdef DUMP_HDR_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          dump_req;
  logic [1:0]    dump_chan;
  logic          dump_abort;
  logic          capture_done;
  logic [AW-1:0] trace_end;
  logic [DW-1:0] ram_rdata = '0;
  logic          tx_done = 1'b0;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [1:0]    chan_sel;
  logic [DW-1:0] tx_data;
  logic          trmt;
  logic          clr_capture_done;
  logic          dump_busy;
  logic          dump_err;

  int n_tests = 0;
  int n_fail  = 0;

  trace_dump_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .dump_chan(dump_chan),
    .dump_abort(dump_abort), .capture_done(capture_done), .trace_end(trace_end),
    .ram_rdata(ram_rdata), .tx_done(tx_done), .ram_en(ram_en), .ram_addr(ram_addr),
    .chan_sel(chan_sel), .tx_data(tx_data), .trmt(trmt),
    .clr_capture_done(clr_capture_done), .dump_busy(dump_busy), .dump_err(dump_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, one-cycle read latency
  always @(posedge clk) if (ram_en) ram_rdata <= ram_addr[7:0];

  // UART model; can also raise abort together with the Nth tx_done of a dump
  int   pend     = 0;
  int   done_cnt = 0;
  int   abort_at = 0;
  logic abort_sync = 1'b0;
  logic abort_lvl  = 1'b0;
  assign dump_abort = abort_lvl | abort_sync;

  always @(negedge clk) begin
    tx_done    = 1'b0;
    abort_sync = 1'b0;
    if (!rst_n) begin
      pend     = 0;
      done_cnt = 0;
    end else begin
      if (!dump_busy) done_cnt = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          tx_done = 1'b1;
          done_cnt++;
          if (abort_at != 0 && done_cnt == abort_at) abort_sync = 1'b1;
        end
      end
      if (trmt) pend = UART_LAT;
    end
  end

  // Output monitor: logs every byte sent and every RAM address read
  logic [7:0]    byte_log[$];
  logic [AW-1:0] addr_log[$];
  int   trmt_cnt = 0, ren_cnt = 0, clr_cnt = 0, err_cnt = 0;
  logic ab_q = 1'b0;
  logic busy_after_abort = 1'b1;

  always @(posedge clk) ab_q <= dump_abort;

  always @(negedge clk) begin
    if (trmt) begin trmt_cnt++; byte_log.push_back(tx_data); end
    if (ram_en) begin ren_cnt++; addr_log.push_back(ram_addr); end
    if (clr_capture_done) clr_cnt++;
    if (dump_err) err_cnt++;
    if (ab_q) busy_after_abort = dump_busy;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] ch);
    dump_chan = ch;
    dump_req  = 1'b1;
    step();
    dump_req  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (dump_busy && n < budget) begin step(); n++; end
    check(tag, 32'(dump_busy), 32'd0);
  endtask

  function automatic logic [AW-1:0] exp_addr(input int te, input int k);
    return AW'((te + 1 + k) % DEPTH);
  endfunction

  function automatic logic [7:0] exp_byte(input int te, input int ch, input int k);
    logic [AW-1:0] a;
    if (k < HDR) return (k == 0) ? 8'hA5 : 8'(ch);
    a = exp_addr(te, k - HDR);
    return a[7:0];
  endfunction

  // Checks one complete dump logged from indices b0/a0 onward
  task automatic check_dump(input string tag, input int te, input int ch,
                            input int b0, input int a0);
    int nb = byte_log.size() - b0;
    int na = addr_log.size() - a0;
    check({tag, " nbytes"}, 32'(nb), 32'(HDR + DEPTH));
    check({tag, " nreads"}, 32'(na), 32'(DEPTH));
    for (int k = 0; k < nb && k < HDR + DEPTH; k++)
      check({tag, " byte"}, 32'(byte_log[b0 + k]), 32'(exp_byte(te, ch, k)));
    for (int k = 0; k < na && k < DEPTH; k++)
      check({tag, " addr"}, 32'(addr_log[a0 + k]), 32'(exp_addr(te, k)));
  endtask

  initial begin
    int b0, a0, t0, c0, r0, e0, n;
    rst_n = 1'b0; dump_req = 1'b0; dump_chan = '0;
    capture_done = 1'b0; trace_end = '0;
    repeat (3) step();

    // Reset state
    check("rst strobes", {27'd0, ram_en, trmt, clr_capture_done, dump_busy, dump_err}, 32'd0);
    check("rst ram_addr", 32'(ram_addr), 32'd0);
    check("rst chan_sel", 32'(chan_sel), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    step();

    // T3: request with no trace ready
    r0 = ren_cnt;
    req(2'd1);
    check("T3 err pulse", 32'(dump_err), 32'd1);
    check("T3 busy", 32'(dump_busy), 32'd0);
    step();
    check("T3 err drop", 32'(dump_err), 32'd0);
    repeat (3) step();
    check("T3 no ram_en", 32'(ren_cnt - r0), 32'd0);

    // T1: trace_end=0x0FF, channel 2; capture_done drops mid-dump
    capture_done = 1'b1; trace_end = 9'h0FF;
    b0 = byte_log.size(); a0 = addr_log.size(); c0 = clr_cnt; r0 = ren_cnt;
    req(2'd2);
    check("T1 busy", 32'(dump_busy), 32'd1);
    check("T1 chan_sel", 32'(chan_sel), 32'd2);
    repeat (40) step();
    capture_done = 1'b0;
    wait_idle("T1 done", 8000);
    check_dump("T1", 9'h0FF, 2, b0, a0);
    check("T1 ram_en cycles", 32'(ren_cnt - r0), 32'(DEPTH));
    check("T1 clr", 32'(clr_cnt - c0), 32'd1);

    // T2: trace_end=0x1FF wraps start address to 0
    capture_done = 1'b1; trace_end = 9'h1FF;
    b0 = byte_log.size(); a0 = addr_log.size(); c0 = clr_cnt; r0 = ren_cnt;
    req(2'd0);
    wait_idle("T2 done", 8000);
    check("T2 first addr", 32'(addr_log[a0]), 32'h000);
    check("T2 last addr", 32'(addr_log[addr_log.size() - 1]), 32'h1FF);
    check("T2 ram_en cycles", 32'(ren_cnt - r0), 32'(DEPTH));
    check_dump("T2", 9'h1FF, 0, b0, a0);
    check("T2 clr", 32'(clr_cnt - c0), 32'd1);

    // T4: abort coincident with the 10th tx_done (abort must win)
    trace_end = 9'h010;
    t0 = trmt_cnt; c0 = clr_cnt;
    abort_at = 10;
    req(2'd1);
    wait_idle("T4 abort idle", 400);
    abort_at = 0;
    check("T4 idle next cycle", 32'(busy_after_abort), 32'd0);
    repeat (10) step();
    check("T4 trmt count", 32'(trmt_cnt - t0), 32'd10);
    check("T4 no clr", 32'(clr_cnt - c0), 32'd0);

    // T4: plain level abort while waiting on the UART
    t0 = trmt_cnt;
    req(2'd1);
    n = 0;
    while (trmt_cnt < t0 + 3 && n < 200) begin step(); n++; end
    step();
    abort_lvl = 1'b1;
    step();
    abort_lvl = 1'b0;
    check("T4b idle", 32'(dump_busy), 32'd0);
    repeat (10) step();
    check("T4b trmt count", 32'(trmt_cnt - t0), 32'd3);

    // T4: trace still valid, re-dump restarts at trace_end+1
    b0 = byte_log.size(); a0 = addr_log.size(); c0 = clr_cnt;
    req(2'd1);
    wait_idle("T4 redump", 8000);
    check_dump("T4 redump", 9'h010, 1, b0, a0);
    check("T4 redump clr", 32'(clr_cnt - c0), 32'd1);

    // T5: extra request during WTX is ignored, then reset during WTX
    trace_end = 9'h0FF;
    t0 = trmt_cnt; e0 = err_cnt;
    req(2'd3);
    n = 0;
    while (trmt_cnt < t0 + 5 && n < 200) begin step(); n++; end
    check("T5 reached byte 5", 32'(trmt_cnt - t0), 32'd5);
    step();
    dump_chan = 2'd1;
    dump_req  = 1'b1;
    step();
    dump_req  = 1'b0;
    check("T5 chan_sel kept", 32'(chan_sel), 32'd3);
    check("T5 still busy", 32'(dump_busy), 32'd1);
    check("T5 no err", 32'(err_cnt - e0), 32'd0);
    n = 0;
    while (trmt_cnt < t0 + 6 && n < 200) begin step(); n++; end
    step();
    rst_n = 1'b0;
    #1;
    check("T5 rst strobes", {27'd0, ram_en, trmt, clr_capture_done, dump_busy, dump_err}, 32'd0);
    check("T5 rst ram_addr", 32'(ram_addr), 32'd0);
    check("T5 rst chan_sel", 32'(chan_sel), 32'd0);
    check("T5 rst tx_data", 32'(tx_data), 32'd0);
    t0 = trmt_cnt; r0 = ren_cnt;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    check("T5 no trmt after rst", 32'(trmt_cnt - t0), 32'd0);
    check("T5 no ram_en after rst", 32'(ren_cnt - r0), 32'd0);
    check("T5 idle after rst", 32'(dump_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
